pow_operand_gen: RTL and testbench

- Upstream stimulus stage for the `pow` unit. Generates a programmable-length stream of 32-bit operands that drives pow's `a` input.
- Three modes:
  - SEQ: 0,1,2,…
  - EVEN: pseudo-random even values.
  - DIV3: pseudo-random values divisible by 3, produced by rejection sampling.
- Output uses a valid/ready handshake. Used both in lab benches and on-chip self-test in front of pow.

---
 rtl/pow_gen_pkg.sv | 21 ++
 rtl/lfsr_galois.sv | 39 +++
 rtl/pow_operand_gen.sv | 165 ++++++++++++++++
 tb/tb_pow_operand_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pow_gen_pkg.sv
// Shared types and constants for the pow operand generator.
package pow_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SEQ  = 2'd0,
        MODE_EVEN = 2'd1,
        MODE_DIV3 = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    // x^32 + x^22 + x^2 + x + 1, Galois form.
    localparam logic [31:0] POLY_DEFAULT = 32'h8020_0003;

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with synchronous seed load. A zero seed would lock the
// register at zero forever, so it is replaced by 1 on load.
module lfsr_galois #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h8020_0003)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: load wins over step; step shifts right and folds in POLY.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            value_d = value_q[0] ? ((value_q >> 1) ^ POLY) : (value_q >> 1);
        end
    end

    // State register, resets to the non-zero value 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= WIDTH'(1);
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pow_operand_gen.sv
// Operand stream generator feeding pow's `a` input. Emits len operands
// (SEQ counter, even LFSR values, or LFSR values divisible by 3 found by
// rejection) over a valid/ready handshake, then pulses done_o.
module pow_operand_gen
    import pow_gen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               LEN_W     = 8,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(POLY_DEFAULT),
    parameter int               DIV3_BITS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] a_o,
    output logic             a_valid_o,
    input  logic             a_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    state_e             state_q;
    mode_e              mode_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   count_q;
    logic [WIDTH-1:0]   seq_q;
    logic [WIDTH-1:0]   a_q;
    logic               a_valid_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]     lfsr_val;
    logic                 lfsr_load;
    logic                 lfsr_step;
    logic                 start_ok;
    logic [WIDTH-1:0]     cand_d;
    logic                 accept_d;
    logic [DIV3_BITS-1:0] div3_cand;
    logic                 xfer;
    logic                 last_xfer;

    // A start is honoured only in IDLE and only for a defined mode.
    assign start_ok  = (state_q == IDLE) && start_i && (mode_e'(mode_i) != MODE_RSVD);

    // Seed is captured with the rest of the configuration; the LFSR only
    // advances while a random mode is producing candidates.
    assign lfsr_load = start_ok;
    assign lfsr_step = (state_q == GEN) && (mode_q != MODE_SEQ);

    lfsr_galois #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed_i),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    assign div3_cand = lfsr_val[DIV3_BITS-1:0];
    assign xfer      = a_valid_q && a_ready_i;
    // Compare one bit wider so count+1 cannot wrap at the maximum length.
    assign last_xfer = (({1'b0, count_q} + (LEN_W+1)'(1)) == {1'b0, len_q});

    // Candidate for the current GEN cycle and whether it may be emitted.
    always_comb begin
        cand_d   = '0;
        accept_d = 1'b0;
        case (mode_q)
            MODE_SEQ: begin
                cand_d   = seq_q;
                accept_d = 1'b1;
            end
            MODE_EVEN: begin
                cand_d   = {lfsr_val[WIDTH-1:1], 1'b0};
                accept_d = 1'b1;
            end
            MODE_DIV3: begin
                cand_d   = WIDTH'(div3_cand);
                accept_d = ((div3_cand % DIV3_BITS'(3)) == '0);
            end
            default: begin
                cand_d   = '0;
                accept_d = 1'b0;
            end
        endcase
    end

    // Control FSM with registered outputs; reset aborts any sequence silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE_SEQ;
            len_q     <= '0;
            count_q   <= '0;
            seq_q     <= '0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_ok) begin
                        mode_q  <= mode_e'(mode_i);
                        len_q   <= len_i;
                        count_q <= '0;
                        seq_q   <= '0;
                        if (len_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= GEN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                GEN: begin
                    if (mode_q == MODE_SEQ) begin
                        seq_q <= seq_q + WIDTH'(1);
                    end
                    // Rejected DIV3 candidates simply retry next cycle.
                    if (accept_d) begin
                        a_q       <= cand_d;
                        a_valid_q <= 1'b1;
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        count_q   <= count_q + LEN_W'(1);
                        a_valid_q <= 1'b0;
                        if (last_xfer) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= GEN;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_o       = a_q;
    assign a_valid_o = a_valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_pow_operand_gen.sv
// Directed self-checking bench for pow_operand_gen.
module tb_pow_operand_gen;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [7:0]  len_i;
    logic [31:0] seed_i;
    logic [31:0] a_o;
    logic        a_valid_o;
    logic        a_ready_i;
    logic        busy_o;
    logic        done_o;

    int n_assert = 0;
    int n_fail   = 0;

    pow_operand_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .mode_i    (mode_i),
        .len_i     (len_i),
        .seed_i    (seed_i),
        .a_o       (a_o),
        .a_valid_o (a_valid_o),
        .a_ready_i (a_ready_i),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] m, input logic [7:0] l, input logic [31:0] s);
        start_i = 1'b1;
        mode_i  = m;
        len_i   = l;
        seed_i  = s;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        mode_i    = 2'd0;
        len_i     = 8'd0;
        seed_i    = 32'd0;
        a_ready_i = 1'b1;
        tick();
        tick();
        check("rst_a", a_o, 32'd0);
        check("rst_valid", {31'd0, a_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        rst = 1'b0;
        tick();

        // SEQ len=5, ready high: 0..4, one-cycle valids, 2-cycle spacing.
        launch(2'd0, 8'd5, 32'd0);
        check("seq_gen_valid", {31'd0, a_valid_o}, 32'd0);
        check("seq_gen_busy", {31'd0, busy_o}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("seq_valid%0d", k), {31'd0, a_valid_o}, 32'd1);
            check($sformatf("seq_a%0d", k), a_o, k);
            tick();
            check($sformatf("seq_drop%0d", k), {31'd0, a_valid_o}, 32'd0);
            check($sformatf("seq_done%0d", k), {31'd0, done_o}, (k == 4) ? 32'd1 : 32'd0);
        end
        check("seq_busy_end", {31'd0, busy_o}, 32'd0);
        tick();
        check("seq_done_pulse", {31'd0, done_o}, 32'd0);
        check("seq_idle_busy", {31'd0, busy_o}, 32'd0);

        // EVEN seed=1 len=2: 0 then 0x80200002.
        launch(2'd1, 8'd2, 32'd1);
        tick();
        check("even_v0", {31'd0, a_valid_o}, 32'd1);
        check("even_a0", a_o, 32'd0);
        tick();
        tick();
        check("even_v1", {31'd0, a_valid_o}, 32'd1);
        check("even_a1", a_o, 32'h8020_0002);
        check("even_lsb", {31'd0, a_o[0]}, 32'd0);
        tick();
        check("even_done", {31'd0, done_o}, 32'd1);
        tick();

        // DIV3 seed=1 len=1: 1 rejected, then 3 accepted.
        launch(2'd2, 8'd1, 32'd1);
        tick();
        check("div3_reject_valid", {31'd0, a_valid_o}, 32'd0);
        check("div3_reject_busy", {31'd0, busy_o}, 32'd1);
        tick();
        check("div3_valid", {31'd0, a_valid_o}, 32'd1);
        check("div3_a", a_o, 32'd3);
        tick();
        check("div3_done", {31'd0, done_o}, 32'd1);
        tick();

        // Seed 0 is replaced by 1: same result as seed 1 in EVEN mode.
        launch(2'd1, 8'd2, 32'd0);
        tick();
        tick();
        tick();
        check("seed0_a1", a_o, 32'h8020_0002);
        tick();
        tick();

        // Backpressure: SEQ len=3, ready low for 4 cycles on first operand.
        a_ready_i = 1'b0;
        launch(2'd0, 8'd3, 32'd0);
        tick();
        check("bp_v0", {31'd0, a_valid_o}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            // A start while busy must be ignored.
            start_i = (k == 1);
            len_i   = 8'd0;
            tick();
            check($sformatf("bp_hold_v%0d", k), {31'd0, a_valid_o}, 32'd1);
            check($sformatf("bp_hold_a%0d", k), a_o, 32'd0);
            check($sformatf("bp_hold_done%0d", k), {31'd0, done_o}, 32'd0);
        end
        start_i   = 1'b0;
        a_ready_i = 1'b1;
        tick();
        check("bp_xfer0", {31'd0, a_valid_o}, 32'd0);
        tick();
        check("bp_a1", a_o, 32'd1);
        tick();
        tick();
        check("bp_a2", a_o, 32'd2);
        check("bp_v2", {31'd0, a_valid_o}, 32'd1);
        tick();
        check("bp_done", {31'd0, done_o}, 32'd1);
        tick();

        // len=0: done one cycle after start, nothing emitted.
        launch(2'd0, 8'd0, 32'd0);
        check("len0_done", {31'd0, done_o}, 32'd1);
        check("len0_valid", {31'd0, a_valid_o}, 32'd0);
        check("len0_busy", {31'd0, busy_o}, 32'd0);
        tick();
        check("len0_done_end", {31'd0, done_o}, 32'd0);

        // Reserved mode: ignored.
        launch(2'd3, 8'd5, 32'd0);
        check("rsvd_busy", {31'd0, busy_o}, 32'd0);
        check("rsvd_done", {31'd0, done_o}, 32'd0);
        tick();
        check("rsvd_valid", {31'd0, a_valid_o}, 32'd0);
        check("rsvd_busy2", {31'd0, busy_o}, 32'd0);

        // Reset while holding a DIV3 operand aborts without done.
        a_ready_i = 1'b0;
        launch(2'd2, 8'd10, 32'd1);
        tick();
        tick();
        check("abort_hold_valid", {31'd0, a_valid_o}, 32'd1);
        check("abort_hold_a", a_o, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", {31'd0, a_valid_o}, 32'd0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_done", {31'd0, done_o}, 32'd0);
        tick();
        check("abort_done2", {31'd0, done_o}, 32'd0);

        // Fresh SEQ run after the abort starts at 0.
        a_ready_i = 1'b1;
        launch(2'd0, 8'd1, 32'd0);
        tick();
        check("fresh_valid", {31'd0, a_valid_o}, 32'd1);
        check("fresh_a", a_o, 32'd0);
        tick();
        check("fresh_done", {31'd0, done_o}, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
